// File: rtl/mor1kx_bus_if_wb_burst.sv
// mor1kx_bus_if_wb_burst
//   Bridges a mor1kx CPU ibus/dbus port to a Wishbone B3 master. It supports
//   a configurable data width, wrapping read bursts of BURST_LENGTH beats,
//   bounded retry on wbm_rty_i, and an optional no-ack watchdog.
//
// Optional feature macro: MOR1KX_BUS_IF_WB_TIMEOUT_EN
//   When defined, a watchdog counts cycles with cyc high and no termination.
//   After TIMEOUT_CYCLES such cycles it raises cpu_err_o and ends the cycle.
//   When undefined, there is no watchdog and the bridge waits indefinitely.
//
// Ports
//   clk, rst                : clock; reset is synchronous and active-low
//   cpu_adr_i/dat_i/req_i/bsel_i/we_i/burst_i : CPU request (held until ack/err)
//   cpu_ack_o, cpu_err_o    : per-beat ack, one-cycle error pulse (combinational)
//   cpu_dat_o               : read data, passed straight through from wbm_dat_i
//   wbm_adr_o/stb_o/cyc_o/we_o/sel_o/cti_o/bte_o/dat_o : registered Wishbone outputs
//   wbm_ack_i/err_i/rty_i/dat_i : Wishbone slave terminations and read data
module mor1kx_bus_if_wb_burst #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_LENGTH   = 8,
    parameter int RETRY_LIMIT    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cpu_adr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_dat_i,
    input  logic                    cpu_req_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_bsel_i,
    input  logic                    cpu_we_i,
    input  logic                    cpu_burst_i,
    output logic                    cpu_ack_o,
    output logic                    cpu_err_o,
    output logic [DATA_WIDTH-1:0]   cpu_dat_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_cyc_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic                    wbm_we_o,
    output logic [2:0]              wbm_cti_o,
    output logic [1:0]              wbm_bte_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int OFF       = $clog2(SEL_WIDTH);
    localparam int BCW       = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

    // Address bits that wrap within a burst; everything else stays fixed.
    localparam logic [ADDR_WIDTH-1:0] WRAP_MASK = ADDR_WIDTH'((BURST_LENGTH - 1) << OFF);
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC  = ADDR_WIDTH'(SEL_WIDTH);
    localparam logic [BCW-1:0]        LAST_BEAT = BCW'(BURST_LENGTH - 1);
    localparam logic [BCW-1:0]        PENULT    = BCW'(BURST_LENGTH - 2);
    localparam logic [3:0]            RTY_LAST  = 4'(RETRY_LIMIT - 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_WRAP    = (BURST_LENGTH == 16) ? 2'b11 :
                                         (BURST_LENGTH == 8)  ? 2'b10 :
                                         (BURST_LENGTH == 4)  ? 2'b01 : 2'b00;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, RTY_WAIT} state_t;

    state_t                  state_q, state_d;
    logic                    cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [2:0]              cti_q, cti_d;
    logic [1:0]              bte_q, bte_d;
    logic [BCW-1:0]          beat_q, beat_d;
    logic [3:0]              rty_cnt_q, rty_cnt_d;

    logic term_err, term_rty, term_ack, rty_fatal, to_fire, err_pulse, go_idle;

    // Priority among terminations: err, then rty, then ack.
    assign term_err  = cyc_q & wbm_err_i;
    assign term_rty  = cyc_q & ~wbm_err_i & wbm_rty_i;
    assign term_ack  = cyc_q & ~wbm_err_i & ~wbm_rty_i & wbm_ack_i;
    assign rty_fatal = term_rty & (rty_cnt_q == RTY_LAST);

`ifdef MOR1KX_BUS_IF_WB_TIMEOUT_EN
    localparam int            TOW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           any_term;

    assign any_term = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign to_fire  = cyc_q & ~any_term & (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = '0;
        if (cyc_q && !any_term)
            to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) to_cnt_q <= '0;
        else      to_cnt_q <= to_cnt_d;
    end
`else
    assign to_fire = 1'b0;
`endif

    assign err_pulse = term_err | rty_fatal | to_fire;

    assign cpu_ack_o = term_ack;
    assign cpu_err_o = err_pulse;
    assign cpu_dat_o = wbm_dat_i;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        cti_d     = cti_q;
        bte_d     = bte_q;
        beat_d    = beat_q;
        rty_cnt_d = rty_cnt_q;
        go_idle   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    we_d      = cpu_we_i;
                    adr_d     = cpu_adr_i;
                    sel_d     = cpu_bsel_i;
                    dat_d     = cpu_dat_i;
                    beat_d    = '0;
                    rty_cnt_d = '0;
                    if (cpu_burst_i && !cpu_we_i && BURST_LENGTH > 1) begin
                        state_d = BURST;
                        cti_d   = CTI_INCR;
                        bte_d   = BTE_WRAP;
                    end else begin
                        state_d = SINGLE;
                        cti_d   = CTI_CLASSIC;
                        bte_d   = 2'b00;
                    end
                end
            end
            SINGLE, BURST: begin
                if (err_pulse) begin
                    go_idle = 1'b1;
                end else if (term_rty) begin
                    // Drop the bus for one cycle, keep adr/cti for the reissue.
                    rty_cnt_d = rty_cnt_q + 1'b1;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    state_d   = RTY_WAIT;
                end else if (term_ack) begin
                    rty_cnt_d = '0;
                    if (state_q == SINGLE || beat_q == LAST_BEAT) begin
                        go_idle = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        adr_d  = (adr_q & ~WRAP_MASK) | ((adr_q + BEAT_INC) & WRAP_MASK);
                        if (beat_q == PENULT)
                            cti_d = CTI_END;
                    end
                end else if (!cpu_req_i) begin
                    go_idle = 1'b1;
                end
            end
            RTY_WAIT: begin
                if (!cpu_req_i) begin
                    go_idle = 1'b1;
                end else begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = (cti_q == CTI_CLASSIC) ? SINGLE : BURST;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d   = IDLE;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            we_d      = 1'b0;
            cti_d     = CTI_CLASSIC;
            bte_d     = 2'b00;
            beat_d    = '0;
            rty_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            cti_q     <= CTI_CLASSIC;
            bte_q     <= 2'b00;
            beat_q    <= '0;
            rty_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            cti_q     <= cti_d;
            bte_q     <= bte_d;
            beat_q    <= beat_d;
            rty_cnt_q <= rty_cnt_d;
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_stb_o = stb_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = dat_q;
    assign wbm_cti_o = cti_q;
    assign wbm_bte_o = bte_q;

endmodule

// File: tb/tb_mor1kx_bus_if_wb_burst.sv
// Directed bench for mor1kx_bus_if_wb_burst: a 32-bit/BL8 instance and a
// 64-bit/BL4 instance share the slave termination inputs; only one is active
// at a time.
module tb_mor1kx_bus_if_wb_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_adr, cpu_dat, wdat_i;
    logic        req, req64, we, burst, ack, err, rty;
    logic [3:0]  bsel;
    logic [7:0]  bsel64;
    logic [63:0] cpu_dat64, wdat_i64;

    logic        cpu_ack, cpu_err, wstb, wcyc, wwe;
    logic [31:0] cpu_dat_o, wadr, wdat_o;
    logic [3:0]  wsel;
    logic [2:0]  wcti;
    logic [1:0]  wbte;

    logic        x_ack, x_err, x_stb, x_cyc, x_we;
    logic [63:0] x_dat_o, x_wdat_o;
    logic [31:0] x_adr;
    logic [7:0]  x_sel;
    logic [2:0]  x_cti;
    logic [1:0]  x_bte;

    int checks = 0;
    int errors = 0;
    int nack;

    always #5 clk = ~clk;

    mor1kx_bus_if_wb_burst #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LENGTH(8),
        .RETRY_LIMIT(3), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_req_i(req),
        .cpu_bsel_i(bsel), .cpu_we_i(we), .cpu_burst_i(burst),
        .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err), .cpu_dat_o(cpu_dat_o),
        .wbm_adr_o(wadr), .wbm_stb_o(wstb), .wbm_cyc_o(wcyc), .wbm_sel_o(wsel),
        .wbm_we_o(wwe), .wbm_cti_o(wcti), .wbm_bte_o(wbte), .wbm_dat_o(wdat_o),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty), .wbm_dat_i(wdat_i)
    );

    mor1kx_bus_if_wb_burst #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LENGTH(4),
        .RETRY_LIMIT(3), .TIMEOUT_CYCLES(16)
    ) u_dut64 (
        .clk(clk), .rst(rst),
        .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat64), .cpu_req_i(req64),
        .cpu_bsel_i(bsel64), .cpu_we_i(we), .cpu_burst_i(burst),
        .cpu_ack_o(x_ack), .cpu_err_o(x_err), .cpu_dat_o(x_dat_o),
        .wbm_adr_o(x_adr), .wbm_stb_o(x_stb), .wbm_cyc_o(x_cyc), .wbm_sel_o(x_sel),
        .wbm_we_o(x_we), .wbm_cti_o(x_cti), .wbm_bte_o(x_bte), .wbm_dat_o(x_wdat_o),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty), .wbm_dat_i(wdat_i64)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b0; req = 1'b0; req64 = 1'b0; we = 1'b0; burst = 1'b0;
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        cpu_adr = '0; cpu_dat = '0; cpu_dat64 = '0; wdat_i = '0; wdat_i64 = '0;
        bsel = 4'hF; bsel64 = 8'hFF;
        step(); step();
        chk("rst_cyc", 64'(wcyc), 64'd0);
        chk("rst_stb", 64'(wstb), 64'd0);
        chk("rst_adr", 64'(wadr), 64'd0);
        chk("rst_cti", 64'(wcti), 64'd0);
        chk("rst_bte", 64'(wbte), 64'd0);
        chk("rst_sel", 64'(wsel), 64'd0);
        chk("rst_we",  64'(wwe),  64'd0);
        chk("rst_dat", 64'(wdat_o), 64'd0);
        chk("rst_err", 64'(cpu_err), 64'd0);
        chk("rst_cyc64", 64'(x_cyc), 64'd0);
        rst = 1'b1;
        step();

        // Single read, two wait states.
        cpu_adr = 32'h100; req = 1'b1;
        step();
        chk("s_cyc", 64'(wcyc), 64'd1);
        chk("s_stb", 64'(wstb), 64'd1);
        chk("s_adr", 64'(wadr), 64'h100);
        chk("s_cti", 64'(wcti), 64'd0);
        chk("s_bte", 64'(wbte), 64'd0);
        chk("s_sel", 64'(wsel), 64'hF);
        chk("s_ack_ws1", 64'(cpu_ack), 64'd0);
        step();
        chk("s_ack_ws2", 64'(cpu_ack), 64'd0);
        step();
        ack = 1'b1; wdat_i = 32'hDEADBEEF; #1;
        chk("s_ack", 64'(cpu_ack), 64'd1);
        chk("s_rdat", 64'(cpu_dat_o), 64'hDEADBEEF);
        step();
        ack = 1'b0; req = 1'b0; #1;
        chk("s_cyc_drop", 64'(wcyc), 64'd0);
        step();

        // Wrapping burst, BL=8, 32-bit.
        cpu_adr = 32'h1018; burst = 1'b1; req = 1'b1; ack = 1'b1;
        step();
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            wdat_i = 32'h5A000000 + i; #1;
            chk($sformatf("b_adr%0d", i), 64'(wadr), 64'(32'h1000 | (((6 + i) % 8) * 4)));
            chk($sformatf("b_cti%0d", i), 64'(wcti), (i == 7) ? 64'd7 : 64'd2);
            chk($sformatf("b_bte%0d", i), 64'(wbte), 64'd2);
            chk($sformatf("b_rdat%0d", i), 64'(cpu_dat_o), 64'(32'h5A000000 + i));
            if (cpu_ack) nack++;
            step();
        end
        req = 1'b0; ack = 1'b0; burst = 1'b0; #1;
        chk("b_cyc_drop", 64'(wcyc), 64'd0);
        chk("b_nack", 64'(nack), 64'd8);
        step();

        // Wrapping burst, BL=4, 64-bit.
        cpu_adr = 32'h2010; burst = 1'b1; req64 = 1'b1; ack = 1'b1;
        step();
        nack = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("w_adr%0d", i), 64'(x_adr), 64'(32'h2000 | (((2 + i) % 4) * 8)));
            chk($sformatf("w_cti%0d", i), 64'(x_cti), (i == 3) ? 64'd7 : 64'd2);
            chk($sformatf("w_bte%0d", i), 64'(x_bte), 64'd1);
            chk($sformatf("w_sel%0d", i), 64'(x_sel), 64'hFF);
            if (x_ack) nack++;
            step();
        end
        req64 = 1'b0; ack = 1'b0; burst = 1'b0; #1;
        chk("w_cyc_drop", 64'(x_cyc), 64'd0);
        chk("w_nack", 64'(nack), 64'd4);
        chk("w_other_idle", 64'(wcyc), 64'd0);
        step();

        // rty (with simultaneous ack), rty, ack.
        cpu_adr = 32'h200; req = 1'b1;
        step();
        ack = 1'b1; rty = 1'b1; #1;
        chk("r_rty_beats_ack", 64'(cpu_ack), 64'd0);
        chk("r_err1", 64'(cpu_err), 64'd0);
        step();
        ack = 1'b0; rty = 1'b0; #1;
        chk("r_gap1", 64'(wcyc), 64'd0);
        step();
        chk("r_reissue1", 64'(wcyc), 64'd1);
        chk("r_adr1", 64'(wadr), 64'h200);
        rty = 1'b1; #1;
        chk("r_err2", 64'(cpu_err), 64'd0);
        step();
        rty = 1'b0; #1;
        chk("r_gap2", 64'(wcyc), 64'd0);
        step();
        chk("r_reissue2", 64'(wcyc), 64'd1);
        ack = 1'b1; #1;
        chk("r_ack", 64'(cpu_ack), 64'd1);
        step();
        ack = 1'b0; req = 1'b0; #1;
        chk("r_cyc_drop", 64'(wcyc), 64'd0);
        step();

        // Three consecutive rty -> error.
        cpu_adr = 32'h300; req = 1'b1; rty = 1'b1;
        step();
        chk("rl_err_a", 64'(cpu_err), 64'd0);
        step();
        chk("rl_gap_a", 64'(wcyc), 64'd0);
        step();
        chk("rl_err_b", 64'(cpu_err), 64'd0);
        step();
        step();
        chk("rl_err_c", 64'(cpu_err), 64'd1);
        step();
        rty = 1'b0; req = 1'b0; #1;
        chk("rl_cyc_drop", 64'(wcyc), 64'd0);
        chk("rl_err_end", 64'(cpu_err), 64'd0);
        step();

        // err on beat 3 of 8 (ack also asserted; err must win).
        cpu_adr = 32'h1018; burst = 1'b1; req = 1'b1; ack = 1'b1;
        step();
        step();
        step();
        err = 1'b1; #1;
        chk("e_adr", 64'(wadr), 64'h1000);
        chk("e_err", 64'(cpu_err), 64'd1);
        chk("e_no_ack", 64'(cpu_ack), 64'd0);
        step();
        err = 1'b0; ack = 1'b0; req = 1'b0; burst = 1'b0; #1;
        chk("e_cyc_drop", 64'(wcyc), 64'd0);
        chk("e_err_end", 64'(cpu_err), 64'd0);
        step();

        // Reset in the middle of a burst.
        cpu_adr = 32'h1018; burst = 1'b1; req = 1'b1; ack = 1'b1;
        step();
        step();
        chk("mr_cti_mid", 64'(wcti), 64'd2);
        rst = 1'b0;
        step();
        chk("mr_cyc", 64'(wcyc), 64'd0);
        chk("mr_stb", 64'(wstb), 64'd0);
        chk("mr_adr", 64'(wadr), 64'd0);
        chk("mr_cti", 64'(wcti), 64'd0);
        chk("mr_bte", 64'(wbte), 64'd0);
        chk("mr_no_ack", 64'(cpu_ack), 64'd0);
        rst = 1'b1; req = 1'b0; ack = 1'b0; burst = 1'b0;
        step();
        chk("mr_idle", 64'(wcyc), 64'd0);

        // Abort: request withdrawn without termination.
        cpu_adr = 32'h400; req = 1'b1;
        step();
        chk("a_cyc", 64'(wcyc), 64'd1);
        req = 1'b0;
        step();
        chk("a_cyc_drop", 64'(wcyc), 64'd0);
        chk("a_no_ack", 64'(cpu_ack), 64'd0);
        chk("a_no_err", 64'(cpu_err), 64'd0);
        step();

        // Write with burst flag set is issued as a classic single cycle.
        cpu_adr = 32'h500; cpu_dat = 32'hCAFEF00D; we = 1'b1; burst = 1'b1;
        bsel = 4'h3; req = 1'b1;
        step();
        chk("wr_we", 64'(wwe), 64'd1);
        chk("wr_dat", 64'(wdat_o), 64'hCAFEF00D);
        chk("wr_cti", 64'(wcti), 64'd0);
        chk("wr_bte", 64'(wbte), 64'd0);
        chk("wr_sel", 64'(wsel), 64'h3);
        ack = 1'b1; #1;
        chk("wr_ack", 64'(cpu_ack), 64'd1);
        step();
        ack = 1'b0; req = 1'b0; we = 1'b0; burst = 1'b0; bsel = 4'hF; #1;
        chk("wr_cyc_drop", 64'(wcyc), 64'd0);
        chk("wr_we_drop", 64'(wwe), 64'd0);
        step();

`ifdef MOR1KX_BUS_IF_WB_TIMEOUT_EN
        // No termination: error on the 16th cycle with cyc high.
        cpu_adr = 32'h600; req = 1'b1;
        step();
        repeat (14) step();
        chk("to_err_15", 64'(cpu_err), 64'd0);
        step();
        chk("to_err_16", 64'(cpu_err), 64'd1);
        step();
        req = 1'b0; #1;
        chk("to_cyc_drop", 64'(wcyc), 64'd0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
